// File: rtl/tc_spi_master.sv
// SPI read-only master for a MAX31855-style thermocouple converter.
// Captures one 32-bit frame per request; CLK_DIV sets the SCLK half-period and CS setup/gap length.
`timescale 1ns/1ps
module tc_spi_master #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_ena,
   input  logic        miso,
   output logic        sclk,
   output logic        cs_n,
   output logic        spi_not_busy,
   output logic [31:0] spi_rx_data,
   output logic        rx_valid
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;
   localparam int unsigned BW = 5;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          sclk_q, sclk_d;
   logic          cs_n_q, cs_n_d;
   logic          not_busy_q, not_busy_d;
   logic          rx_valid_q, rx_valid_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [DW-1:0] rx_data_q, rx_data_d;
   logic          phase_end;

   assign phase_end = (div_q == DIV_LAST);

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         not_busy_q <= 1'b1;
         rx_valid_q <= 1'b0;
         shift_q    <= '0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         not_busy_q <= not_busy_d;
         rx_valid_q <= rx_valid_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
      end
   end

   // Next state, phase divider and bit counter
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            bit_d = '0;
            if (spi_ena) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            if (phase_end) begin
               div_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               div_d = CW'(div_q + CW'(1));
            end
         end
         ST_SHIFT: begin
            if (phase_end) begin
               div_d = '0;
               // A bit ends with its high phase
               if (sclk_q) begin
                  if (bit_q == BIT_LAST) state_d = ST_GAP;
                  else                   bit_d   = BW'(bit_q + BW'(1));
               end
            end else begin
               div_d = CW'(div_q + CW'(1));
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               div_d   = '0;
               state_d = ST_IDLE;
            end else begin
               div_d = CW'(div_q + CW'(1));
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Registered output values, derived from the state being entered
   always_comb begin
      sclk_d     = 1'b0;
      cs_n_d     = 1'b1;
      not_busy_d = 1'b0;
      rx_valid_d = 1'b0;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      case (state_d)
         ST_IDLE:  not_busy_d = 1'b1;
         ST_SETUP: cs_n_d = 1'b0;
         ST_SHIFT: begin
            cs_n_d = 1'b0;
            if (state_q == ST_SHIFT) begin
               sclk_d = sclk_q ^ phase_end;
               if (phase_end && !sclk_q) shift_d = {shift_q[DW-2:0], miso};
            end
         end
         ST_GAP: begin
            if (state_q == ST_SHIFT) begin
               rx_valid_d = 1'b1;
               rx_data_d  = shift_q;
            end
         end
         default: not_busy_d = 1'b1;
      endcase
   end

   assign sclk         = sclk_q;
   assign cs_n         = cs_n_q;
   assign spi_not_busy = not_busy_q;
   assign rx_valid     = rx_valid_q;
   assign spi_rx_data  = rx_data_q;

endmodule

// File: tb/tb_tc_spi_master.sv
// Directed bench for tc_spi_master: converter models feed miso, a scoreboard checks each frame.
`timescale 1ns/1ps
module tb_tc_spi_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena2 = 1'b0, miso2 = 1'b0, sclk2, cs_n2, nb2, rv2;
   logic        ena1 = 1'b0, miso1 = 1'b0, sclk1, cs_n1, nb1, rv1;
   logic [31:0] data2, data1;

   always #5 clk = ~clk;

   tc_spi_master #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst), .spi_ena(ena2), .miso(miso2), .sclk(sclk2), .cs_n(cs_n2),
      .spi_not_busy(nb2), .spi_rx_data(data2), .rx_valid(rv2));

   tc_spi_master #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .spi_ena(ena1), .miso(miso1), .sclk(sclk1), .cs_n(cs_n1),
      .spi_not_busy(nb1), .spi_rx_data(data1), .rx_valid(rv1));

   int n_assert = 0;
   int n_fail   = 0;
   int pcnt     = 0;
   always @(posedge clk) pcnt <= pcnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Converter models: first bit on CS fall, next bit on each SCLK fall
   logic [31:0] slv2_q[$], slv1_q[$];
   logic [31:0] slv2_w = '0, slv1_w = '0;
   int          slv2_idx = 0, slv1_idx = 0;

   always @(negedge cs_n2) begin
      slv2_w   = (slv2_q.size() > 0) ? slv2_q.pop_front() : 32'd0;
      slv2_idx = 31;
      miso2    = slv2_w[31];
   end
   always @(negedge sclk2) if (slv2_idx > 0) begin
      slv2_idx--;
      miso2 = slv2_w[slv2_idx];
   end
   always @(negedge cs_n1) begin
      slv1_w   = (slv1_q.size() > 0) ? slv1_q.pop_front() : 32'd0;
      slv1_idx = 31;
      miso1    = slv1_w[31];
   end
   always @(negedge sclk1) if (slv1_idx > 0) begin
      slv1_idx--;
      miso1 = slv1_w[slv1_idx];
   end

   // Scoreboard and waveform-shape monitor for the CLK_DIV=2 instance
   logic [31:0] exp2_q[$];
   logic [31:0] exp_w;
   int   rv_cnt2 = 0, rv_edge2 = 0, rise2 = 0, chg_cyc = 0, cs_rise_cyc = 0;
   int   rv_cnt1 = 0, rv_edge1 = 0;
   logic sclk2_p = 1'b0, cs2_p = 1'b1, rv2_p = 1'b0;
   bit   have_prev = 0, cs_seen = 0;

   always @(negedge clk) begin
      if (rst && (sclk2 !== sclk2_p)) begin
         if (have_prev) chk("sclk_phase_width", 32'(pcnt - chg_cyc), 32'd2);
         chg_cyc   = pcnt;
         have_prev = 1;
         if (sclk2) rise2++;
      end
      if (!rst || cs_n2) have_prev = 0;
      if (cs2_p && !cs_n2) begin
         rise2 = 0;
         if (cs_seen) chk("cs_high_min", 32'((pcnt - cs_rise_cyc) >= 2), 32'd1);
      end
      if (!cs2_p && cs_n2) begin
         cs_rise_cyc = pcnt;
         cs_seen     = 1;
      end
      if (rv2) begin
         chk("rv_single_cycle", 32'(rv2_p), 32'd0);
         chk("sclk_rises", 32'(rise2), 32'd32);
         rv_cnt2++;
         rv_edge2 = pcnt;
         chk("rv_expected", 32'(exp2_q.size() > 0), 32'd1);
         if (exp2_q.size() > 0) begin
            exp_w = exp2_q.pop_front();
            chk("frame_data", data2, exp_w);
         end
      end
      if (rv1) begin
         rv_cnt1++;
         rv_edge1 = pcnt;
      end
      sclk2_p = sclk2;
      cs2_p   = cs_n2;
      rv2_p   = rv2;
   end

   task automatic wait_nb2(output int e);
      bit found = 0;
      e = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (nb2) begin
            found = 1;
            e     = pcnt;
         end
      end
      chk("nb2_wait", 32'(found), 32'd1);
   endtask

   task automatic start2(input logic [31:0] w, input bit done, output int e0);
      slv2_q.push_back(w);
      if (done) exp2_q.push_back(w);
      @(negedge clk);
      ena2 = 1'b1;
      @(negedge clk);
      e0   = pcnt;
      ena2 = 1'b0;
      chk("start_cs_n", 32'(cs_n2), 32'd0);
      chk("start_not_busy", 32'(nb2), 32'd0);
   endtask

   int e0, e, rvb;
   bit found;

   initial begin
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_cs_n", 32'(cs_n2), 32'd1);
      chk("rst_sclk", 32'(sclk2), 32'd0);
      chk("rst_not_busy", 32'(nb2), 32'd1);
      chk("rst_rx_valid", 32'(rv2), 32'd0);
      chk("rst_data", data2, 32'd0);
      chk("rst_cs_n_div1", 32'(cs_n1), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_no_ena_nb", 32'(nb2), 32'd1);
      chk("idle_no_ena_cs", 32'(cs_n2), 32'd1);

      // Basic frame, one-cycle request
      start2(32'hA5A5_0F0F, 1, e0);
      wait_nb2(e);
      chk("basic_busy_len", 32'(e - e0), 32'd132);
      chk("basic_rv_edge", 32'(rv_edge2 - e0), 32'd130);
      chk("basic_rv_cnt", 32'(rv_cnt2), 32'd1);
      chk("basic_data", data2, 32'hA5A5_0F0F);

      // Minimum divide
      slv1_q.push_back(32'h8000_0001);
      @(negedge clk);
      ena1 = 1'b1;
      @(negedge clk);
      e0   = pcnt;
      ena1 = 1'b0;
      found = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (nb1) begin
            found = 1;
            e     = pcnt;
         end
      end
      chk("div1_done", 32'(found), 32'd1);
      chk("div1_busy_len", 32'(e - e0), 32'd66);
      chk("div1_rv_edge", 32'(rv_edge1 - e0), 32'd65);
      chk("div1_rv_cnt", 32'(rv_cnt1), 32'd1);
      chk("div1_data", data1, 32'h8000_0001);

      // Request held high across two frames
      slv2_q.push_back(32'h1234_5678); exp2_q.push_back(32'h1234_5678);
      slv2_q.push_back(32'hFFFF_0000); exp2_q.push_back(32'hFFFF_0000);
      @(negedge clk);
      ena2 = 1'b1;
      @(negedge clk);
      e0 = pcnt;
      wait_nb2(e);
      chk("held_first_len", 32'(e - e0), 32'd132);
      @(negedge clk);
      chk("held_idle_one_cycle", 32'(nb2), 32'd0);
      chk("held_rv_cnt1", 32'(rv_cnt2), 32'd2);
      ena2 = 1'b0;
      repeat (60) @(negedge clk);
      chk("held_data_hold", data2, 32'h1234_5678);
      wait_nb2(e);
      chk("held_second_len", 32'(e - e0), 32'd265);
      chk("held_rv_edge2", 32'(rv_edge2 - e0), 32'd263);
      chk("held_rv_cnt2", 32'(rv_cnt2), 32'd3);
      chk("held_data2", data2, 32'hFFFF_0000);

      // Request toggled while busy
      start2(32'h3C96_E1D2, 1, e0);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (nb2) begin
            found = 1;
            e     = pcnt;
            ena2  = 1'b0;
         end else begin
            ena2 = ~ena2;
         end
      end
      chk("toggle_done", 32'(found), 32'd1);
      chk("toggle_busy_len", 32'(e - e0), 32'd132);
      chk("toggle_rv_edge", 32'(rv_edge2 - e0), 32'd130);
      chk("toggle_rv_cnt", 32'(rv_cnt2), 32'd4);
      repeat (3) @(negedge clk);
      chk("toggle_no_restart", 32'(nb2), 32'd1);

      // Asynchronous reset mid-frame
      start2(32'hDEAD_BEEF, 0, e0);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1;
         if (rise2 >= 10) found = 1;
      end
      chk("midreset_reach", 32'(found), 32'd1);
      chk("midreset_sclk_high", 32'(sclk2), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("midreset_cs_n", 32'(cs_n2), 32'd1);
      chk("midreset_sclk", 32'(sclk2), 32'd0);
      chk("midreset_nb", 32'(nb2), 32'd1);
      chk("midreset_rv", 32'(rv2), 32'd0);
      chk("midreset_data", data2, 32'd0);
      chk("midreset_data_div1", data1, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (150) @(negedge clk);
      chk("midreset_no_rv", 32'(rv_cnt2), 32'd4);
      chk("midreset_idle", 32'(nb2), 32'd1);
      chk("midreset_data_after", data2, 32'd0);

      // Consumer handshake
      rvb = rv_cnt2;
      slv2_q.push_back(32'h0F1E_2D3C); exp2_q.push_back(32'h0F1E_2D3C);
      slv2_q.push_back(32'h55AA_33CC); exp2_q.push_back(32'h55AA_33CC);
      for (int f = 0; f < 2; f++) begin
         @(negedge clk);
         ena2 = 1'b1;
         found = 0;
         for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!nb2) found = 1;
         end
         ena2 = 1'b0;
         chk("hs_accept", 32'(found), 32'd1);
         wait_nb2(e);
      end
      repeat (20) @(negedge clk);
      chk("hs_rv_cnt", 32'(rv_cnt2 - rvb), 32'd2);
      chk("hs_idle", 32'(nb2), 32'd1);
      chk("hs_data", data2, 32'h55AA_33CC);
      chk("sb_drained", 32'(exp2_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
